sysid_probe_ctrl: RTL
=====================

// Module: sysid_probe_ctrl
// PURPOSE
//  Avalon-MM master that reads the system ID peripheral's control slave at boot,
//  and again on request, to verify the loaded FPGA image.
//  Reads word 0 (ID) then word 1 (build timestamp) and compares both against
//  expected values. Drives busy/done/match/error status to the HPS-facing status
//  register and the board LEDs.
//  Sits between the system ID slave and the status/LED logic in the top-level computer.
// PARAMETERS
//  EXPECTED_ID     32'd0           expected value at word address 0
//  EXPECTED_TS     32'd1617249225  expected value at word address 1
//  TIMEOUT_CYCLES  255             max consecutive waitrequest-high cycles per read (1..255)
//  MAX_RETRIES     3               read-sequence attempts before FAIL (1..3)
// PORTS
//  clock            in   1   system clock; all logic on rising edge
//  reset_n          in   1   asynchronous, active-low reset
//  start            in   1   1-cycle pulse; re-runs the check when idle (DONE/FAIL)
//  avm_address      out  1   word address to system ID slave (0=ID, 1=timestamp)
//  avm_read         out  1   read strobe
//  avm_readdata     in   32  read data; valid in any cycle with avm_read=1 and avm_waitrequest=0
//  avm_waitrequest  in   1   slave stall
//  id_value         out  32  last captured ID word
//  ts_value         out  32  last captured timestamp word
//  busy             out  1   high while in RD_ID/RD_TS/COMPARE
//  done             out  1   level; high in DONE
//  match            out  1   level; valid when done=1; 1 = both words equal expected
//  error_timeout    out  1   level; high in FAIL
//  retry_count      out  2   timed-out attempts in current run (saturates at MAX_RETRIES)
// BEHAVIOUR
//  Reset (async assert): state=BOOT. All outputs 0, including avm_read, avm_address,
//   id_value, ts_value, retry_count and the timeout counter.
//  States: BOOT, RD_ID, RD_TS, COMPARE, DONE, FAIL.
//  BOOT: one cycle after reset release, unconditionally -> RD_ID (self-start).
//  RD_ID: avm_read=1, avm_address=0.
//   - Read ends on the first edge with waitrequest=0: capture readdata into id_value,
//     clear the timeout counter, -> RD_TS.
//  RD_TS: avm_read=1, avm_address=1; same rules; capture into ts_value, -> COMPARE.
//  Timeout: the counter increments on each edge in RD_ID/RD_TS with waitrequest=1.
//   - When it reaches TIMEOUT_CYCLES: retry_count+1, counter cleared, avm_read=0 for 1 cycle.
//   - Then if retry_count < MAX_RETRIES: restart at RD_ID (id_value is re-read).
//   - Else: -> FAIL.
//   - If waitrequest=0 on the same edge the counter would hit the limit, the capture
//     wins: no timeout.
//  COMPARE: one cycle, avm_read=0; match <= (id_value==EXPECTED_ID) && (ts_value==EXPECTED_TS);
//   -> DONE. A mismatch is final and is never retried.
//  DONE: done=1, match held; FAIL: error_timeout=1, match=0. Both hold until start.
//  start in DONE/FAIL: clear done/match/error_timeout/retry_count, -> RD_ID next edge.
//   id_value/ts_value keep their old values until re-captured.
//  start in BOOT/RD_ID/RD_TS/COMPARE: ignored (no queuing).
//  avm_address and avm_read are stable while waitrequest=1 (Avalon rule).
//  Latency, zero wait states: reset release -> BOOT(edge1) -> RD_ID(e2) -> RD_TS(e3)
//   -> COMPARE(e4) -> DONE(e5). done=1 after the 5th edge; start-to-done = 4 edges.
//  Reset mid-read: avm_read drops immediately (async); sequence restarts from BOOT.
// TESTING
//  1 Zero-wait slave, ID=0, TS=1617249225 -> done=1, match=1 at 5th edge after reset,
//    retry_count=0.
//  2 Slave TS=32'h0000_0001 -> done=1, match=0, ts_value=1; exactly 2 reads issued, no retry.
//  3 waitrequest=1 for 3 cycles on each read -> done at edge 11, match=1, busy high
//    throughout, address stable during stalls.
//  4 TIMEOUT_CYCLES=4, waitrequest stuck high -> 3 attempts, retry_count=3,
//    error_timeout=1, avm_read=0 in FAIL.
//  5 waitrequest drops on the edge the counter hits 4 -> capture accepted,
//    retry_count=0, match=1.
//  6 start while busy -> ignored. start in DONE -> done clears, new run, done again
//    4 edges later. Reset asserted mid-RD_TS -> avm_read=0 immediately, full rerun.

Source files
------------

// File: rtl/sysid_probe_ctrl.sv
// rtl/sysid_probe_ctrl.sv - boot-time system ID / timestamp probe over Avalon-MM
// Reads ID and build timestamp, compares to expected values, retries on slave timeout.

module sysid_probe_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1617249225,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        error_timeout,
    output logic [1:0]  retry_count
);

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_RD_ID   = 3'd1,
        ST_RD_TS   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    localparam logic [7:0] TO_LAST     = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRIES);

    state_t      r_state;
    logic        r_boot_armed;
    logic [7:0]  r_to_cnt;
    logic        r_avm_address;
    logic        r_avm_read;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;
    logic        r_busy;
    logic        r_done;
    logic        r_match;
    logic        r_error_timeout;
    logic [1:0]  r_retry_count;

    logic        w_accept;
    logic        w_stall_limit;
    logic [1:0]  w_retry_inc;

    // A waitrequest-low edge always wins over a timeout landing on the same edge.
    assign w_accept      = r_avm_read & ~avm_waitrequest;
    assign w_stall_limit = r_avm_read & avm_waitrequest & (r_to_cnt == TO_LAST);
    assign w_retry_inc   = r_retry_count + 2'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_BOOT;
            r_boot_armed    <= 1'b0;
            r_to_cnt        <= 8'd0;
            r_avm_address   <= 1'b0;
            r_avm_read      <= 1'b0;
            r_id_value      <= 32'd0;
            r_ts_value      <= 32'd0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_match         <= 1'b0;
            r_error_timeout <= 1'b0;
            r_retry_count   <= 2'd0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (!r_boot_armed) begin
                        r_boot_armed <= 1'b1;
                    end else begin
                        r_state       <= ST_RD_ID;
                        r_avm_read    <= 1'b1;
                        r_avm_address <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                ST_RD_ID, ST_RD_TS: begin
                    if (!r_avm_read) begin
                        // one idle cycle after a timeout, then the ID read is reissued
                        r_avm_read <= 1'b1;
                    end else if (w_accept) begin
                        r_to_cnt <= 8'd0;
                        if (r_state == ST_RD_ID) begin
                            r_id_value    <= avm_readdata;
                            r_avm_address <= 1'b1;
                            r_state       <= ST_RD_TS;
                        end else begin
                            r_ts_value    <= avm_readdata;
                            r_avm_read    <= 1'b0;
                            r_avm_address <= 1'b0;
                            r_state       <= ST_COMPARE;
                        end
                    end else if (w_stall_limit) begin
                        r_to_cnt      <= 8'd0;
                        r_avm_read    <= 1'b0;
                        r_avm_address <= 1'b0;
                        r_retry_count <= w_retry_inc;
                        if (w_retry_inc >= RETRY_LIMIT) begin
                            r_state         <= ST_FAIL;
                            r_busy          <= 1'b0;
                            r_error_timeout <= 1'b1;
                            r_match         <= 1'b0;
                        end else begin
                            r_state <= ST_RD_ID;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                ST_COMPARE: begin
                    r_match <= (r_id_value == EXPECTED_ID) && (r_ts_value == EXPECTED_TS);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_DONE;
                end
                ST_DONE, ST_FAIL: begin
                    if (start) begin
                        r_done          <= 1'b0;
                        r_match         <= 1'b0;
                        r_error_timeout <= 1'b0;
                        r_retry_count   <= 2'd0;
                        r_to_cnt        <= 8'd0;
                        r_avm_read      <= 1'b1;
                        r_avm_address   <= 1'b0;
                        r_busy          <= 1'b1;
                        r_state         <= ST_RD_ID;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign avm_address   = r_avm_address;
    assign avm_read      = r_avm_read;
    assign id_value      = r_id_value;
    assign ts_value      = r_ts_value;
    assign busy          = r_busy;
    assign done          = r_done;
    assign match         = r_match;
    assign error_timeout = r_error_timeout;
    assign retry_count   = r_retry_count;

endmodule
